// File: rtl/vlsu_meta_fork_queue.sv
// vlsu_meta_fork_queue
// Meta FIFO between the request fragmenter and its two consumers. Each head
// entry is forked to the data controller (DC) and the transaction control
// unit (TC) with independent handshakes, and pops once both halves are done.
// Store metas accepted by TC are tracked until their final B response. TC is
// throttled at MaxOutst outstanding stores. With FenceLoads set, loads are
// optionally fenced behind in-flight stores.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   enq_valid_i/enq_ready_o         fragmenter handshake
//   enq_meta_i, enq_is_store_i      fragmenter payload
//   dc_valid_o/dc_ready_i           DC handshake, dc_meta_o head payload
//   tc_valid_o/tc_ready_i           TC handshake
//   tc_meta_o, tc_is_store_o        TC head payload
//   b_last_i                        final B of one store meta (pulse)
//   count_o                         occupied entries
//   outst_o                         outstanding store metas
//   idle_o                          queue empty and no store outstanding
//   err_o                           sticky: b_last_i seen with nothing outstanding
module vlsu_meta_fork_queue #(
    parameter int unsigned MetaW      = 64,
    parameter int unsigned Depth      = 4,
    parameter int unsigned MaxOutst   = 8,
    parameter int unsigned FenceLoads = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enq_valid_i,
    output logic                          enq_ready_o,
    input  logic [MetaW-1:0]              enq_meta_i,
    input  logic                          enq_is_store_i,
    output logic                          dc_valid_o,
    input  logic                          dc_ready_i,
    output logic [MetaW-1:0]              dc_meta_o,
    output logic                          tc_valid_o,
    input  logic                          tc_ready_i,
    output logic [MetaW-1:0]              tc_meta_o,
    output logic                          tc_is_store_o,
    input  logic                          b_last_i,
    output logic [$clog2(Depth):0]        count_o,
    output logic [$clog2(MaxOutst+1)-1:0] outst_o,
    output logic                          idle_o,
    output logic                          err_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned OutW  = $clog2(MaxOutst + 1);
    localparam logic [OutW-1:0] OutMax = OutW'(MaxOutst);

    logic [MetaW-1:0] mem_q [Depth];
    logic [Depth-1:0] st_q;
    logic [PtrW-1:0]  wptr_q, rptr_q, count_q, count_n;
    logic [OutW-1:0]  outst_q, outst_n;
    logic             dc_done_q, tc_done_q, dc_done_n, tc_done_n;
    logic             err_q, idle_q;

    logic             empty, full, head_store, tc_block;
    logic             push, pop, dc_fire, tc_fire, inc, dec;
    logic [AddrW-1:0] head_idx;

    // Pointer state and fork qualification, all from registers
    assign head_idx   = rptr_q[AddrW-1:0];
    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) &&
                        (wptr_q[AddrW] != rptr_q[AddrW]);
    assign head_store = st_q[head_idx];
    assign tc_block   = (head_store && (outst_q == OutMax)) ||
                        ((FenceLoads != 0) && !head_store && (outst_q != '0));

    assign enq_ready_o   = !full;
    assign dc_valid_o    = !empty && !dc_done_q;
    assign tc_valid_o    = !empty && !tc_done_q && !tc_block;
    assign dc_meta_o     = mem_q[head_idx];
    assign tc_meta_o     = mem_q[head_idx];
    assign tc_is_store_o = head_store;
    assign count_o       = count_q;
    assign outst_o       = outst_q;
    assign idle_o        = idle_q;
    assign err_o         = err_q;

    // Handshakes, pop decision and next-state counters
    always_comb begin
        push      = enq_valid_i && !full;
        dc_fire   = dc_valid_o && dc_ready_i;
        tc_fire   = tc_valid_o && tc_ready_i;
        dc_done_n = dc_done_q || dc_fire;
        tc_done_n = tc_done_q || tc_fire;
        pop       = !empty && dc_done_n && tc_done_n;
        inc       = tc_fire && head_store;
        dec       = b_last_i && (outst_q != '0);

        // Flags restart for the next head on pop
        if (pop) begin
            dc_done_n = 1'b0;
            tc_done_n = 1'b0;
        end

        count_n = count_q;
        if (push && !pop) begin
            count_n = count_q + PtrW'(1);
        end else if (pop && !push) begin
            count_n = count_q - PtrW'(1);
        end

        outst_n = outst_q;
        if (inc && !dec) begin
            outst_n = outst_q + OutW'(1);
        end else if (dec && !inc) begin
            outst_n = outst_q - OutW'(1);
        end
    end

    // Control state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            dc_done_q <= 1'b0;
            tc_done_q <= 1'b0;
            err_q     <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q   <= count_n;
            outst_q   <= outst_n;
            dc_done_q <= dc_done_n;
            tc_done_q <= tc_done_n;
            idle_q    <= (count_n == '0) && (outst_n == '0);
            if (b_last_i && (outst_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Payload storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AddrW-1:0]] <= enq_meta_i;
            st_q[wptr_q[AddrW-1:0]]  <= enq_is_store_i;
        end
    end

endmodule
